// File: rtl/fpu_pkg.sv
// fpu_pkg: shared FP32 widths and FPU opcodes used by the sequencer, fpu_top and the bench
package fpu_pkg;
  localparam int FP_W = 32;
  localparam int OP_W = 4;
  typedef logic [FP_W-1:0] fp_t;
  typedef logic [OP_W-1:0] op_t;
  localparam op_t OP_ADD = 4'd0;
  localparam op_t OP_SUB = 4'd1;
  localparam op_t OP_MUL = 4'd2;
  localparam op_t OP_DIV = 4'd3;
  localparam op_t OP_CMP = 4'd4;
endpackage

// File: rtl/fpu_rsp_fifo.sv
// fpu_rsp_fifo: synchronous FIFO with occupancy count and a registered head word
module fpu_rsp_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   occ
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_nxt;
  logic one_left;
  assign rd_nxt = rd_ptr + 1'b1;
  assign one_left = occ == (AW+1)'(1);
  // dout always mirrors mem[rd_ptr]; when the only entry leaves during a push, the pushed word becomes the head
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ <= '0;
      dout <= '0;
    end else begin
      if (push) mem[wr_ptr] <= din;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_nxt;
      occ <= occ + (AW+1)'(push) - (AW+1)'(pop);
      if (pop) dout <= one_left ? din : mem[rd_nxt];
      else if (push && occ == '0) dout <= din;
    end
  end
  always @(posedge clk)
    if (!rst) assert (!(push && occ == (AW+1)'(DEPTH)));
endmodule

// File: rtl/fpu_cmd_sequencer.sv
// fpu_cmd_sequencer: issues FP32 commands to fpu_top, tracks its fixed latency and
// returns results in order through a credit-protected response FIFO
module fpu_cmd_sequencer
  import fpu_pkg::*;
#(
  parameter int FPU_LATENCY = 2,
  parameter int RSP_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [FP_W-1:0] cmd_num1,
  input  logic [FP_W-1:0] cmd_num2,
  input  logic [OP_W-1:0] cmd_op,
  output logic [FP_W-1:0] fpu_num1,
  output logic [FP_W-1:0] fpu_num2,
  output logic [OP_W-1:0] fpu_op,
  input  logic [FP_W-1:0] fpu_result,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [FP_W-1:0] rsp_result,
  output logic            busy
);
  localparam int CW = $clog2(RSP_DEPTH) + 1;
  logic [FPU_LATENCY-1:0] issue_pipe;
  logic [FPU_LATENCY:0] pipe_next;
  logic [CW-1:0] inflight, occ;
  logic accept, capture, pop;
  assign accept = cmd_valid && cmd_ready;
  assign pipe_next = {issue_pipe, accept};
  assign capture = issue_pipe[FPU_LATENCY-1];
  assign pop = rsp_valid && rsp_ready;
  always_comb begin
    inflight = '0;
    for (int i = 0; i < FPU_LATENCY; i++) inflight = inflight + CW'(issue_pipe[i]);
  end
  // credits count only registered state, so a pop frees its slot one cycle later
  assign cmd_ready = !rst && ({1'b0, inflight} + {1'b0, occ}) < (CW+1)'(RSP_DEPTH);
  assign rsp_valid = occ != '0;
  assign busy = inflight != '0 || occ != '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      issue_pipe <= '0;
      fpu_num1 <= '0;
      fpu_num2 <= '0;
      fpu_op <= '0;
    end else begin
      issue_pipe <= pipe_next[FPU_LATENCY-1:0];
      if (accept) begin
        fpu_num1 <= cmd_num1;
        fpu_num2 <= cmd_num2;
        fpu_op <= cmd_op;
      end
    end
  end
  fpu_rsp_fifo #(.DEPTH(RSP_DEPTH), .W(FP_W)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(capture),
    .din(fpu_result),
    .pop(pop),
    .dout(rsp_result),
    .occ(occ)
  );
endmodule

// File: tb/tb_fpu_cmd_sequencer.sv
// tb_fpu_cmd_sequencer: FP32-add stub behind the sequencer, queue-based reference model and directed tests
module tb_fpu_cmd_sequencer;
  import fpu_pkg::*;
  localparam int L = 2;
  localparam int D = 4;
  localparam logic [31:0] F1 = 32'h3F800000, F3 = 32'h40400000, F5 = 32'h40A00000;
  localparam logic [31:0] F10 = 32'h41200000, FM10 = 32'hC1200000, FM3 = 32'hC0400000;
  logic clk = 0, rst = 1;
  logic cmd_valid = 0, cmd_ready, rsp_valid, rsp_ready = 0, busy;
  logic [31:0] cmd_num1 = 0, cmd_num2 = 0, fpu_num1, fpu_num2, fpu_result, rsp_result;
  logic [3:0] cmd_op = 0, fpu_op;
  int n_checks = 0, n_fail = 0, t = 0;
  always #5 clk = ~clk;

  fpu_cmd_sequencer #(.FPU_LATENCY(L), .RSP_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_num1(cmd_num1), .cmd_num2(cmd_num2), .cmd_op(cmd_op),
    .fpu_num1(fpu_num1), .fpu_num2(fpu_num2), .fpu_op(fpu_op), .fpu_result(fpu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result), .busy(busy));

  function automatic real fp2r(input logic [31:0] b);
    real m;
    int e;
    if ($isunknown(b) || b[30:23] == 8'd0) return 0.0;
    m = 1.0 + real'(b[22:0]) / 8388608.0;
    e = int'(b[30:23]) - 127;
    for (int i = 0; i < e; i++) m = m * 2.0;
    for (int i = 0; i > e; i--) m = m / 2.0;
    return b[31] ? -m : m;
  endfunction

  function automatic logic [31:0] r2fp(input real r);
    real a;
    int e;
    logic s;
    if (r == 0.0) return 32'h0;
    e = 0;
    s = r < 0.0;
    a = s ? -r : r;
    while (a >= 2.0 && e < 200) begin a = a / 2.0; e++; end
    while (a < 1.0 && e > -200) begin a = a * 2.0; e--; end
    return {s, 8'(e + 127), 23'(longint'((a - 1.0) * 8388608.0))};
  endfunction

  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    return r2fp(fp2r(a) + fp2r(b));
  endfunction

  // fpu_top stand-in: one register stage gives the two-edge latency seen by the sequencer
  always @(posedge clk) fpu_result <= fp_add(fpu_num1, fpu_num2);

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, t);
    end
  endfunction

  typedef struct { logic [31:0] res; int rdy; } ent_t;
  ent_t mq[$];
  bit live = 0;
  logic [31:0] m_n1, m_n2;
  logic [3:0] m_op;
  logic [31:0] got[$];
  int got_t[$], acc_t[$];

  always @(posedge clk) t++;

  // reference model: an op accepted at edge k lands in the FIFO at edge k+L; outstanding ops never exceed D
  always @(negedge clk) begin
    int m_occ;
    bit m_valid, pop, acc;
    m_occ = 0;
    foreach (mq[i]) if (mq[i].rdy <= t) m_occ++;
    m_valid = mq.size() > 0 && mq[0].rdy <= t;
    if (live) begin
      chk("cmd_ready", 32'(cmd_ready), 32'(!rst && mq.size() < D));
      chk("rsp_valid", 32'(rsp_valid), 32'(m_valid));
      if (m_valid) chk("rsp_result", rsp_result, mq[0].res);
      chk("busy", 32'(busy), 32'(mq.size() != 0));
      chk("occ", 32'(dut.occ), 32'(m_occ));
      chk("fpu_num1", fpu_num1, m_n1);
      chk("fpu_num2", fpu_num2, m_n2);
      chk("fpu_op", 32'(fpu_op), 32'(m_op));
    end
    if (!rst && cmd_valid && cmd_ready) acc_t.push_back(t + 1);
    if (!rst && rsp_valid && rsp_ready) begin got.push_back(rsp_result); got_t.push_back(t); end
    if (rst) begin
      mq.delete();
      m_n1 = 0; m_n2 = 0; m_op = 0;
      live = 1;
    end else if (live) begin
      pop = m_valid && rsp_ready;
      acc = cmd_valid && mq.size() < D;
      if (pop) void'(mq.pop_front());
      if (acc) begin
        mq.push_back('{fp_add(cmd_num1, cmd_num2), t + 1 + L});
        m_n1 = cmd_num1; m_n2 = cmd_num2; m_op = cmd_op;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    bit ok;
    ok = 0;
    cmd_valid = 1; cmd_num1 = a; cmd_num2 = b; cmd_op = op;
    for (int k = 0; k < 60 && !ok; k++) begin @(negedge clk); ok = cmd_ready; end
    chk("send_accepted", 32'(ok), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic clear_log();
    got.delete(); got_t.delete(); acc_t.delete();
  endtask

  logic [31:0] exp5 [5] = '{32'h41700000, 32'h41000000, 32'h40000000, 32'hC0A00000, 32'hC1500000};
  logic [31:0] exp6 [6] = '{32'h40000000, 32'h41000000, 32'h41700000, 32'hC0A00000, 32'hC1500000, 32'h40800000};
  logic [31:0] exp4 [4] = '{32'h40000000, 32'h41000000, 32'h41700000, 32'h40800000};

  initial begin
    cyc(2);
    chk("reset_cmd_ready", 32'(cmd_ready), 0);
    chk("reset_rsp_valid", 32'(rsp_valid), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_rsp_result", rsp_result, 0);
    chk("reset_fpu_num1", fpu_num1, 0);
    rst = 0;
    rsp_ready = 1;
    #1 chk("ready_after_reset", 32'(cmd_ready), 1);
    // single op
    clear_log();
    send(F10, F5, OP_ADD);
    cmd_valid = 0;
    cyc(6);
    chk("single_count", got.size(), 1);
    chk("single_result", got.size() > 0 ? got[0] : 32'hx, 32'h41700000);
    chk("single_latency", got_t.size() > 0 && acc_t.size() > 0 ? got_t[0] - acc_t[0] : -1, 2);
    // back-to-back
    clear_log();
    send(F10, F5, OP_ADD); send(F3, F5, OP_ADD); send(F1, F1, OP_ADD);
    send(FM10, F5, OP_ADD); send(FM10, FM3, OP_ADD);
    cmd_valid = 0;
    cyc(8);
    chk("b2b_accepts", acc_t.size(), 5);
    chk("b2b_span", acc_t.size() == 5 ? acc_t[4] - acc_t[0] : -1, 4);
    chk("b2b_count", got.size(), 5);
    for (int i = 0; i < 5; i++) chk($sformatf("b2b_result%0d", i), i < got.size() ? got[i] : 32'hx, exp5[i]);
    // backpressure: only D accepted while stalled
    clear_log();
    rsp_ready = 0;
    fork
      begin
        send(F1, F1, OP_ADD); send(F3, F5, OP_ADD); send(F10, F5, OP_ADD);
        send(FM10, F5, OP_ADD); send(FM10, FM3, OP_ADD); send(F1, F3, OP_ADD);
        cmd_valid = 0;
      end
      begin
        cyc(10);
        chk("stall_accepts", acc_t.size(), D);
        chk("stall_cmd_ready", 32'(cmd_ready), 0);
        chk("stall_head", rsp_result, 32'h40000000);
        cyc(3);
        chk("stall_head_hold", rsp_result, 32'h40000000);
        rsp_ready = 1;
      end
    join
    cyc(10);
    chk("drain_count", got.size(), 6);
    for (int i = 0; i < 6; i++) chk($sformatf("drain_result%0d", i), i < got.size() ? got[i] : 32'hx, exp6[i]);
    // simultaneous push and pop at 3/4
    clear_log();
    rsp_ready = 0;
    send(F1, F1, OP_ADD); send(F3, F5, OP_ADD); send(F10, F5, OP_ADD); send(F1, F3, OP_ADD);
    cmd_valid = 0;
    for (int k = 0; k < 20 && dut.occ != 3; k++) cyc(1);
    chk("pp_occ_before", 32'(dut.occ), 3);
    rsp_ready = 1;
    cyc(1);
    rsp_ready = 0;
    chk("pp_occ_after", 32'(dut.occ), 3);
    chk("pp_head", rsp_result, 32'h41000000);
    rsp_ready = 1;
    cyc(8);
    chk("pp_count", got.size(), 4);
    for (int i = 0; i < 4; i++) chk($sformatf("pp_result%0d", i), i < got.size() ? got[i] : 32'hx, exp4[i]);
    // reset with 2 in flight, 1 queued
    clear_log();
    rsp_ready = 0;
    send(F10, F5, OP_ADD); send(F3, F5, OP_ADD); send(F1, F1, OP_ADD);
    cmd_valid = 0;
    chk("pre_reset_occ", 32'(dut.occ), 1);
    chk("pre_reset_busy", 32'(busy), 1);
    rst = 1;
    cyc(1);
    rst = 0;
    chk("midreset_rsp_valid", 32'(rsp_valid), 0);
    chk("midreset_busy", 32'(busy), 0);
    chk("midreset_fpu_num1", fpu_num1, 0);
    chk("midreset_fpu_num2", fpu_num2, 0);
    chk("midreset_fpu_op", 32'(fpu_op), 0);
    rsp_ready = 1;
    cyc(10);
    chk("no_stale_rsp", got.size(), 0);
    // idle hold
    clear_log();
    send(F1, F3, OP_SUB);
    cmd_valid = 0;
    cyc(6);
    chk("idle_fpu_num1", fpu_num1, F1);
    chk("idle_fpu_num2", fpu_num2, F3);
    chk("idle_fpu_op", 32'(fpu_op), 32'(OP_SUB));
    chk("idle_busy", 32'(busy), 0);
    chk("idle_result", got.size() > 0 ? got[0] : 32'hx, 32'h40800000);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/fpu_cmd_sequencer.md
# fpu_cmd_sequencer

Initiator-side front end for `fpu_top`. Accepts FP32 operation commands over a valid/ready stream and drives the FPU operand/op inputs. It tracks each issued operation through the FPU's fixed latency, captures `result` at the correct cycle, and returns results in order over a valid/ready response stream. Credit-based flow control means a result is never dropped when the downstream consumer stalls.

## Interface

Parameters:

- `FPU_LATENCY`, default 2: cycles from the edge that updates `fpu_num1/fpu_num2/fpu_op` to the edge at which `fpu_result` is valid. Legal range 1..8.
- `RSP_DEPTH`, default 4: response FIFO entries. Power of 2, at least 2. This is also the maximum number of outstanding operations.

Ports:

- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  command accepted when high together with `cmd_valid`.
- `cmd_num1`  in  32  FP32 operand 1.
- `cmd_num2`  in  32  FP32 operand 2.
- `cmd_op`  in  4  FPU opcode, passed through unmodified.
- `fpu_num1`  out  32  to `fpu_top.num1`.
- `fpu_num2`  out  32  to `fpu_top.num2`.
- `fpu_op`  out  4  to `fpu_top.op`.
- `fpu_result`  in  32  from `fpu_top.result`.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  consumer takes the response.
- `rsp_result`  out  32  FP32 result, in command order.
- `busy`  out  1  at least one operation is in flight or a response is pending.

## Operation

- Accept on `cmd_valid && cmd_ready`. At that edge, register `cmd_num1/cmd_num2/cmd_op` into `fpu_num1/fpu_num2/fpu_op`. These outputs hold their value until the next accept.
- Issue tracking is a shift register `issue_pipe[FPU_LATENCY-1:0]`. Bit 0 is set on accept, the register shifts every cycle, and a bit exiting at the top marks the capture cycle.
- Capture: at the edge where the exiting bit is 1, `fpu_result` is pushed into the response FIFO.
- Credits:
  - `inflight` is the count of set bits in `issue_pipe`.
  - `occ` is the FIFO occupancy.
  - `cmd_ready = !rst && (inflight + occ) < RSP_DEPTH`.
  - A same-cycle pop does not grant a credit in that cycle. `cmd_ready` is therefore a function of registered state only.
- Response side: `rsp_valid = (occ != 0)`. `rsp_result` is the FIFO head. Pop on `rsp_valid && rsp_ready`.
- Simultaneous push and pop: `occ` is unchanged and the data order is preserved.
- A push into a full FIFO cannot occur because of the credit rule. An assertion flags it in simulation.
- `busy = (inflight != 0) || (occ != 0)`.
- Width rules:
  - `inflight` and `occ` are each `$clog2(RSP_DEPTH)+1` bits.
  - FIFO pointers are `$clog2(RSP_DEPTH)` bits and wrap naturally.
- Back-to-back accepts are legal, one per cycle. While accepts are back-to-back, the FPU sees a new operand set every cycle.

## Timing

- Reset values (synchronous, `rst` high at an edge): `fpu_num1 = 0`, `fpu_num2 = 0`, `fpu_op = 0`, `issue_pipe = 0`, FIFO empty, `rsp_valid = 0`, `rsp_result = 0`, `busy = 0`, `cmd_ready = 0` while `rst` is high.
- Reset mid-operation: in-flight operations and queued responses are discarded, and no response is produced for them. `cmd_ready` rises in the first cycle after `rst` falls.
- Latency: accept at edge E0 puts the FIFO push at edge E(FPU_LATENCY). With an empty FIFO, `rsp_valid` is high in the cycle after E(FPU_LATENCY), so the latency is `FPU_LATENCY` cycles.
- Throughput is 1 op/cycle, provided `RSP_DEPTH` ≥ `FPU_LATENCY + 1` and the consumer is always ready.
- Handshake rules:
  - `rsp_valid`/`rsp_result` remain stable while `rsp_valid && !rsp_ready`.
  - `cmd_ready` may drop without `cmd_valid` being seen.

## Structure

- Shared package `fpu_pkg`:
  - `FP_W = 32`
  - `OP_W = 4`
  - opcode `localparam`s (add/sub/mul/div/compare), also used by `fpu_top` and the bench.
- One sub-module: `fpu_rsp_fifo`, a synchronous FIFO with parameters `DEPTH` and `W`, a push/pop interface, an `occ` output and registered read data.
- Issue pipe and credit logic sit at top level.

## Test plan

Bench connects a behavioural FP32-add stub with `FPU_LATENCY` = 2.

- Reset, then a single command 0x41200000 + 0x40A00000 with `rsp_ready` = 1 -> `rsp_valid` is high for exactly one cycle, 2 cycles after accept, with `rsp_result` = 0x41700000.
- Five back-to-back commands (10+5, 3+5, 1+1, −10+5, −10−3) with `rsp_ready` = 1 -> accepted in 5 consecutive cycles. Results come back in order: 0x41700000, 0x41000000, 0x40000000, 0xC0A00000, 0xC1500000.
- Hold `rsp_ready` = 0 and issue 6 commands -> exactly `RSP_DEPTH` = 4 are accepted, then `cmd_ready` = 0 and `rsp_result` stays stable. Raising `rsp_ready` drains the 4 results in order and the remaining 2 commands are then accepted.
- Simultaneous push and pop with the FIFO at 3/4 -> `occ` stays at 3 and no data is lost or reordered.
- Assert `rst` for one cycle with 2 operations in flight and 1 response queued -> after reset `rsp_valid` = 0, `busy` = 0 and `fpu_*` = 0, and no stale response ever appears.
- Idle after operations -> `fpu_num1/fpu_num2/fpu_op` hold the last accepted values and `busy` = 0.
